// File: rtl/cic_decim_sequencer_if.sv
// Signal bundle between the CIC decimation sequencer, the CIC datapath and the sample consumer.
// master = sequencer side, slave = environment (front-end, datapath, consumer) side.
interface cic_decim_sequencer_if #(
  parameter int WIDTH_DATA  = 5,
  parameter int WIDTH_RATIO = 4
);
  logic                   start;
  logic                   stop;
  logic                   cfg_load;
  logic [WIDTH_RATIO-1:0] ratio_cfg;
  logic                   in_valid;
  logic                   integ_en;
  logic                   comb_strobe;
  logic [WIDTH_DATA-1:0]  comb_data;
  logic [WIDTH_DATA-1:0]  out_data;
  logic                   out_valid;
  logic                   out_ready;
  logic                   overrun;
  logic                   busy;
  logic [3:0]             ovr_count;

  modport master (
    input  start, stop, cfg_load, ratio_cfg, in_valid, comb_data, out_ready,
    output integ_en, comb_strobe, out_data, out_valid, overrun, busy, ovr_count
  );

  modport slave (
    output start, stop, cfg_load, ratio_cfg, in_valid, comb_data, out_ready,
    input  integ_en, comb_strobe, out_data, out_valid, overrun, busy, ovr_count
  );
endinterface

// File: rtl/cic_decim_sequencer.sv
// Sequencer for the CIC decimator: integrator enable, ratio-R comb strobe, settle discard and
// valid/ready output register. Define CIC_SEQ_OVR_CNT_EN to build the saturating dropped-sample counter.
module cic_decim_sequencer #(
  parameter int STAGES        = 2,
  parameter int WIDTH_DATA    = 5,
  parameter int WIDTH_RATIO   = 4,
  parameter int DEFAULT_RATIO = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  cic_decim_sequencer_if.master bus
);

  localparam int SETTLE_W = $clog2(STAGES + 1);
  localparam logic [WIDTH_RATIO-1:0] RATIO_RST   = WIDTH_RATIO'(DEFAULT_RATIO - 1);
  localparam logic [SETTLE_W-1:0]    SETTLE_LAST = SETTLE_W'(STAGES - 1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_RUN    = 2'd2
  } state_t;

  state_t                 state_q, state_d;
  logic [WIDTH_RATIO-1:0] ratio_q, ratio_d;
  logic [WIDTH_RATIO-1:0] phase_q, phase_d;
  logic [SETTLE_W-1:0]    settle_q, settle_d;
  logic                   strobe_q, strobe_d;
  logic                   capture_q, capture_d;
  logic [WIDTH_DATA-1:0]  out_data_q, out_data_d;
  logic                   out_valid_q, out_valid_d;
  logic                   overrun_q, overrun_d;

  logic busy;
  logic start_go;
  logic capture;
  logic keep;
  logic drop;

  assign busy     = (state_q != ST_IDLE);
  assign start_go = (state_q == ST_IDLE) & bus.start & ~bus.stop;
  // A stop sampled on the capture edge cancels that capture as well as anything still in flight.
  assign capture  = capture_q & busy & ~bus.stop;
  assign keep     = capture & (state_q == ST_RUN);
  assign drop     = keep & out_valid_q & ~bus.out_ready;

  always_comb begin
    state_d   = state_q;
    ratio_d   = ratio_q;
    phase_d   = phase_q;
    settle_d  = settle_q;
    strobe_d  = 1'b0;
    capture_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bus.cfg_load) begin
          ratio_d = bus.ratio_cfg;
        end
        if (start_go) begin
          state_d  = ST_SETTLE;
          phase_d  = '0;
          settle_d = '0;
        end
      end
      ST_SETTLE, ST_RUN: begin
        if (bus.stop) begin
          state_d = ST_IDLE;
          phase_d = '0;
        end else begin
          capture_d = strobe_q;
          if (bus.in_valid) begin
            if (phase_q == ratio_q) begin
              phase_d  = '0;
              strobe_d = 1'b1;
            end else begin
              phase_d = phase_q + WIDTH_RATIO'(1);
            end
          end
          // Settling captures are thrown away; the last one hands over to RUN.
          if (capture && (state_q == ST_SETTLE)) begin
            settle_d = settle_q + SETTLE_W'(1);
            if (settle_q == SETTLE_LAST) begin
              state_d = ST_RUN;
            end
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_comb begin
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    overrun_d   = overrun_q;
    if (start_go) begin
      overrun_d = 1'b0;
    end
    if (keep && (!out_valid_q || bus.out_ready)) begin
      out_data_d  = bus.comb_data;
      out_valid_d = 1'b1;
    end else if (drop) begin
      overrun_d = 1'b1;
    end else if (out_valid_q && bus.out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      ratio_q     <= RATIO_RST;
      phase_q     <= '0;
      settle_q    <= '0;
      strobe_q    <= 1'b0;
      capture_q   <= 1'b0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      ratio_q     <= ratio_d;
      phase_q     <= phase_d;
      settle_q    <= settle_d;
      strobe_q    <= strobe_d;
      capture_q   <= capture_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      overrun_q   <= overrun_d;
    end
  end

`ifdef CIC_SEQ_OVR_CNT_EN
  logic [3:0] ovr_cnt_q, ovr_cnt_d;

  always_comb begin
    ovr_cnt_d = ovr_cnt_q;
    if (start_go) begin
      ovr_cnt_d = 4'd0;
    end else if (drop && (ovr_cnt_q != 4'hF)) begin
      ovr_cnt_d = ovr_cnt_q + 4'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovr_cnt_q <= 4'd0;
    end else begin
      ovr_cnt_q <= ovr_cnt_d;
    end
  end

  assign bus.ovr_count = ovr_cnt_q;
`else
  assign bus.ovr_count = 4'd0;
`endif

  assign bus.integ_en    = bus.in_valid & busy;
  assign bus.comb_strobe = strobe_q;
  assign bus.out_data    = out_data_q;
  assign bus.out_valid   = out_valid_q;
  assign bus.overrun     = overrun_q;
  assign bus.busy        = busy;

endmodule

// File: tb/tb_cic_decim_sequencer.sv
// Bench for cic_decim_sequencer: scoreboard of predicted strobe cycles and output words,
// a per-cycle vector table for the R=1 run, and hand sequences for overrun, stop and reset.
module tb_cic_decim_sequencer;
  localparam int STAGES = 2;
  localparam int WD     = 5;
  localparam int WR     = 4;
`ifdef CIC_SEQ_OVR_CNT_EN
  localparam bit OVR_EN = 1'b1;
`else
  localparam bit OVR_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  cic_decim_sequencer_if #(.WIDTH_DATA(WD), .WIDTH_RATIO(WR)) bus_if ();

  cic_decim_sequencer #(
    .STAGES(STAGES), .WIDTH_DATA(WD), .WIDTH_RATIO(WR), .DEFAULT_RATIO(4)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus_if)
  );

  typedef struct {
    int vis;
    logic [WD-1:0] data;
  } word_t;

  typedef struct {
    int st, sp, cl, rc, iv, orr;
    int e_busy, e_integ, e_strobe, e_valid;
  } vec_t;

  int    checks   = 0;
  int    failures = 0;
  int    cyc      = 0;
  int    m_R      = 4;
  int    m_ph     = 0;
  int    m_nstrb  = 0;
  bit    m_busy   = 1'b0;
  bit    word_sb_en = 1'b1;
  int    sq[$];
  word_t wq[$];
  vec_t  vecs[13];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic drive(input int st, input int sp, input int cl, input int rc, input int iv, input int orr);
    bus_if.start     = (st != 0);
    bus_if.stop      = (sp != 0);
    bus_if.cfg_load  = (cl != 0);
    bus_if.ratio_cfg = WR'(rc);
    bus_if.in_valid  = (iv != 0);
    bus_if.out_ready = (orr != 0);
  endtask

  task automatic purge(input int c);
    int ns = sq.size();
    int nw = wq.size();
    for (int i = 0; i < ns; i++) begin
      int v = sq.pop_front();
      if (v <= c) sq.push_back(v);
    end
    for (int i = 0; i < nw; i++) begin
      word_t w = wq.pop_front();
      if (w.vis <= c) wq.push_back(w);
    end
  endtask

  // Negedge monitor: every strobe and every accepted word is matched against the scoreboard.
  task automatic sample_phase();
    @(negedge clk);
    if (bus_if.comb_strobe === 1'b1) begin
      int e = (sq.size() != 0) ? sq.pop_front() : -1;
      chk("strobe_cycle", cyc, e);
    end
    if (word_sb_en && (bus_if.out_valid === 1'b1) && (bus_if.out_ready === 1'b1)) begin
      word_t w = '{vis: -1, data: '0};
      if (wq.size() != 0) w = wq.pop_front();
      $display("cyc=%0d word out=%0h exp=%0h", cyc, bus_if.out_data, w.data);
      chk("word_cycle", cyc, w.vis);
      chk("word_data", 32'(bus_if.out_data), 32'(w.data));
    end
  endtask

  // Reference prediction from the inputs sampled at the coming edge, then advance one cycle.
  task automatic edge_phase();
    int c = cyc;
    if (rst_n) begin
      if (!m_busy) begin
        if (bus_if.cfg_load) m_R = int'(bus_if.ratio_cfg) + 1;
        if (bus_if.start && !bus_if.stop) begin
          m_busy  = 1'b1;
          m_ph    = 0;
          m_nstrb = 0;
        end
      end else if (bus_if.stop) begin
        m_busy = 1'b0;
        purge(c);
      end else if (bus_if.in_valid) begin
        if (m_ph == m_R - 1) begin
          m_ph = 0;
          m_nstrb++;
          sq.push_back(c + 1);
          if (m_nstrb > STAGES && word_sb_en) wq.push_back('{vis: c + 3, data: WD'(c + 2)});
        end else begin
          m_ph++;
        end
      end
    end
    @(posedge clk);
    #1;
    cyc++;
    bus_if.comb_data = WD'(cyc);
  endtask

  task automatic tick();
    sample_phase();
    edge_phase();
  endtask

  task automatic run_to(input int t);
    while (cyc < t) tick();
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_busy"},      32'(bus_if.busy), 0);
    chk({tag, "_integ_en"},  32'(bus_if.integ_en), 0);
    chk({tag, "_strobe"},    32'(bus_if.comb_strobe), 0);
    chk({tag, "_out_valid"}, 32'(bus_if.out_valid), 0);
    chk({tag, "_out_data"},  32'(bus_if.out_data), 0);
    chk({tag, "_overrun"},   32'(bus_if.overrun), 0);
    chk({tag, "_ovr_count"}, 32'(bus_if.ovr_count), 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int s;
    vecs[0]  = '{0, 0, 1, 0, 1, 1, 0, 0, 0, 0};
    vecs[1]  = '{1, 0, 0, 0, 1, 1, 0, 0, 0, 0};
    vecs[2]  = '{0, 0, 0, 0, 1, 1, 1, 1, 0, 0};
    for (int i = 3; i <= 9; i++) vecs[i] = '{0, 0, 0, 0, 1, 1, 1, 1, 1, (i >= 7) ? 1 : 0};
    vecs[10] = '{0, 1, 0, 0, 1, 1, 1, 1, 1, 1};
    vecs[11] = '{0, 0, 0, 0, 1, 1, 0, 0, 0, 0};
    vecs[12] = '{0, 0, 0, 0, 0, 1, 0, 0, 0, 0};

    // Asynchronous reset, checked before any clock edge.
    rst_n = 1'b1;
    drive(0, 0, 0, 0, 0, 0);
    bus_if.comb_data = '0;
    #1 rst_n = 1'b0;
    #2 chk_all_zero("reset");
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    cyc = 0;
    bus_if.comb_data = '0;

    // Default R=4, continuous input, consumer always ready; cfg_load mid-RUN must be ignored.
    word_sb_en = 1'b1;
    drive(1, 0, 0, 0, 1, 1);
    s = cyc;
    tick();
    drive(0, 0, 0, 0, 1, 1);
    run_to(s + 14);
    sample_phase();
    chk("r4_no_valid_yet", 32'(bus_if.out_valid), 0);
    edge_phase();
    sample_phase();
    chk("r4_first_valid", 32'(bus_if.out_valid), 1);
    chk("r4_first_data", 32'(bus_if.out_data), (s + 14) & 31);
    edge_phase();
    run_to(s + 20);
    drive(0, 0, 1, 7, 1, 1);
    tick();
    drive(0, 0, 0, 0, 1, 1);
    run_to(s + 44);
    drive(0, 1, 0, 0, 1, 1);
    tick();
    drive(0, 0, 0, 0, 0, 1);
    repeat (6) tick();
    chk("r4_strobes_pending", sq.size(), 0);
    chk("r4_words_pending", wq.size(), 0);

    // R=1 table: load in IDLE, start, back-to-back strobes, then stop.
    for (int i = 0; i < 13; i++) begin
      drive(vecs[i].st, vecs[i].sp, vecs[i].cl, vecs[i].rc, vecs[i].iv, vecs[i].orr);
      sample_phase();
      chk($sformatf("vec%0d_busy", i),      32'(bus_if.busy),        vecs[i].e_busy);
      chk($sformatf("vec%0d_integ_en", i),  32'(bus_if.integ_en),    vecs[i].e_integ);
      chk($sformatf("vec%0d_strobe", i),    32'(bus_if.comb_strobe), vecs[i].e_strobe);
      chk($sformatf("vec%0d_out_valid", i), 32'(bus_if.out_valid),   vecs[i].e_valid);
      edge_phase();
    end
    chk("r1_strobes_pending", sq.size(), 0);
    chk("r1_words_pending", wq.size(), 0);

    // R=2 with a stalled consumer: first kept word held, later captures dropped.
    drive(0, 0, 1, 1, 0, 0);
    tick();
    word_sb_en = 1'b0;
    drive(1, 0, 0, 0, 1, 0);
    s = cyc;
    tick();
    drive(0, 0, 0, 0, 1, 0);
    run_to(s + 10);
    sample_phase();
    chk("ovr_first_valid", 32'(bus_if.out_valid), 1);
    chk("ovr_first_data", 32'(bus_if.out_data), (s + 8) & 31);
    chk("ovr_not_yet", 32'(bus_if.overrun), 0);
    edge_phase();
    run_to(s + 15);
    sample_phase();
    chk("ovr_flag", 32'(bus_if.overrun), 1);
    chk("ovr_count_3", 32'(bus_if.ovr_count), OVR_EN ? 3 : 0);
    edge_phase();
    run_to(s + 45);
    sample_phase();
    chk("ovr_count_sat", 32'(bus_if.ovr_count), OVR_EN ? 15 : 0);
    chk("ovr_data_held", 32'(bus_if.out_data), (s + 8) & 31);
    edge_phase();
    drive(0, 1, 0, 0, 0, 1);
    tick();
    drive(0, 0, 0, 0, 0, 1);
    sample_phase();
    chk("ovr_drained", 32'(bus_if.out_valid), 0);
    chk("ovr_idle", 32'(bus_if.busy), 0);
    chk("ovr_sticky_idle", 32'(bus_if.overrun), 1);
    edge_phase();

    // start+stop together in RUN with a held word: stop wins, word survives until consumed.
    drive(1, 0, 0, 0, 1, 0);
    s = cyc;
    tick();
    drive(0, 0, 0, 0, 1, 0);
    run_to(s + 10);
    drive(1, 1, 0, 0, 1, 0);
    sample_phase();
    chk("ss_busy_before", 32'(bus_if.busy), 1);
    edge_phase();
    drive(0, 0, 0, 0, 1, 0);
    sample_phase();
    chk("ss_busy_after", 32'(bus_if.busy), 0);
    chk("ss_integ_idle", 32'(bus_if.integ_en), 0);
    chk("ss_valid_kept", 32'(bus_if.out_valid), 1);
    chk("ss_data_kept", 32'(bus_if.out_data), (s + 8) & 31);
    chk("ss_no_overrun", 32'(bus_if.overrun), 0);
    edge_phase();
    repeat (6) tick();
    sample_phase();
    chk("ss_valid_held", 32'(bus_if.out_valid), 1);
    edge_phase();
    drive(0, 0, 0, 0, 0, 1);
    tick();
    sample_phase();
    chk("ss_valid_consumed", 32'(bus_if.out_valid), 0);
    edge_phase();

    // Reset mid-RUN with a word pending, then confirm the ratio is back to its default.
    drive(1, 0, 0, 0, 1, 0);
    s = cyc;
    tick();
    drive(0, 0, 0, 0, 1, 0);
    run_to(s + 12);
    chk("pre_reset_valid", 32'(bus_if.out_valid), 1);
    #2 rst_n = 1'b0;
    #1 chk_all_zero("midrun_reset");
    sq.delete();
    wq.delete();
    m_busy = 1'b0;
    m_R = 4;
    drive(0, 0, 0, 0, 0, 0);
    tick();
    tick();
    rst_n = 1'b1;
    word_sb_en = 1'b1;
    drive(1, 0, 0, 0, 1, 1);
    s = cyc;
    tick();
    drive(0, 0, 0, 0, 1, 1);
    run_to(s + 24);
    drive(0, 1, 0, 0, 0, 1);
    tick();
    drive(0, 0, 0, 0, 0, 1);
    repeat (6) tick();
    chk("rst_strobes_pending", sq.size(), 0);
    chk("rst_words_pending", wq.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
